// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter.
// Holds the arbiter FSM state encoding and the default bus geometry
// (32 KiB x 8 bank, CPU clock divided by 2**CPU_DIV_W from clk).
package ram_arbiter_pkg;

  localparam int CPU_DIV_W = 4;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_ACC,
    ST_CPU_CAP,
    ST_CPU_WAIT,
    ST_DMA_ACC,
    ST_DMA_CAP
  } state_t;

endpackage

// File: rtl/ram_arbiter_edge_detect.sv
// edge_detect: registers a slow clock-like signal into the clk domain and
// flags its falling edge.
//   clk, reset_n : system clock, async active-low reset
//   sig          : raw input (the divided CPU clock)
//   sig_q        : registered copy of sig (resets high)
//   fall         : one-clk pulse, the cycle after sig_q goes low
module edge_detect
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic sig_q,
  output logic fall
);

  logic sig_q_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q   <= 1'b1;
      sig_q_d <= 1'b1;
    end else begin
      sig_q   <= sig;
      sig_q_d <= sig_q;
    end
  end

  assign fall = sig_q_d & ~sig_q;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between a CPU running on a divided clock and a DMA requester.
// The CPU has priority; it is served within the low phase of cpu_clk.
//   clk, reset_n                          : system clock, async active-low reset
//   cpu_clk, cpu_sel, cpu_wr, cpu_addr,
//   cpu_wdata, cpu_rdata                  : CPU bus (valid while cpu_clk is low)
//   dma_req, dma_we, dma_addr, dma_wdata,
//   dma_ack, dma_rdata                    : DMA request/ack handshake
//   ram_addr, ram_we, ram_wdata, ram_rdata: RAM port
// Optional: define RAM_ARB_STATS_EN to add dma_stall_cnt, a saturating count
// of cycles a DMA request waits.
module ram_arbiter #(
  parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_clk,
  input  logic              cpu_sel,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       dma_stall_cnt
`endif
);

  import ram_arbiter_pkg::*;

  state_t state;
  logic   cpu_q;
  logic   cpu_fall;
  logic   cpu_pend;
  logic   cpu_rd;

  edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (cpu_clk),
    .sig_q   (cpu_q),
    .fall    (cpu_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      dma_ack   <= 1'b0;
      cpu_pend  <= 1'b0;
      cpu_rd    <= 1'b0;
    end else begin
      ram_we  <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A pending edge is consumed here whether or not it was selected.
          cpu_pend <= 1'b0;
          if ((cpu_fall || cpu_pend) && cpu_sel) begin
            state     <= ST_CPU_ACC;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
            ram_we    <= cpu_wr;
            cpu_rd    <= ~cpu_wr;
          // The requester drops dma_req on the edge that ends the ack cycle,
          // so a request seen alongside dma_ack is the one just served.
          end else if (dma_req && !dma_ack) begin
            state     <= ST_DMA_ACC;
            ram_addr  <= dma_addr;
            ram_wdata <= dma_wdata;
            ram_we    <= dma_we;
          end
        end
        ST_CPU_ACC: state <= ST_CPU_CAP;
        ST_CPU_CAP: begin
          if (cpu_rd) cpu_rdata <= ram_rdata;
          state <= ST_CPU_WAIT;
        end
        ST_CPU_WAIT: begin
          if (cpu_q) begin
            if (dma_req) begin
              state     <= ST_DMA_ACC;
              ram_addr  <= dma_addr;
              ram_wdata <= dma_wdata;
              ram_we    <= dma_we;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DMA_ACC: begin
          if (cpu_fall) cpu_pend <= 1'b1;
          state <= ST_DMA_CAP;
        end
        ST_DMA_CAP: begin
          if (cpu_fall) cpu_pend <= 1'b1;
          if (!dma_we) dma_rdata <= ram_rdata;
          dma_ack <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_stall_cnt <= '0;
    end else if (dma_req && state != ST_DMA_ACC && state != ST_DMA_CAP &&
                 dma_stall_cnt != 16'hFFFF) begin
      dma_stall_cnt <= dma_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
